ram512x16_burst_reader: RTL
===========================

# ram512x16_burst_reader

Single-clock burst read master for the 512x16 block-RAM wrapper. It accepts a start address and word count, drives the RAM read port (RA, RClk_En), absorbs the RAM's fixed read latency, and delivers the words in order on a valid/ready output stream with full backpressure. It sits between the RAM read port and any streaming consumer, for example a UART transmitter or a checksum engine. It is the read-side counterpart to the existing write-side clients of the RAM.

## Interface
- ADDR_W, 9, RAM address width.
- DATA_W, 16, RAM data width.
- RD_LATENCY, 1, RAM read latency in clocks (1 = unregistered read, 2 = registered read). Only the values 1 and 2 are legal.
- FIFO_DEPTH, 4, output buffer depth. Must be a power of 2 and at least RD_LATENCY+2.

- Clk  in  1  single clock. The RAM's RClk is tied to this clock.
- Rst  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle request. Ignored while Busy=1.
- StartAddr  in  ADDR_W  first address, sampled when a Start is accepted.
- Len  in  ADDR_W+1  word count, sampled when a Start is accepted. Valid range 0..512; values above 512 are clamped to 512.
- Busy  out  1  high from the cycle after an accepted Start until Done.
- Done  out  1  one-cycle pulse at the end of a burst.
- RA  out  ADDR_W  RAM read address.
- RClk_En  out  1  RAM read enable. Exactly one read is issued per cycle in which it is high.
- RD  in  DATA_W  RAM read data.
- DOut  out  DATA_W  stream data.
- DValid  out  1  stream valid.
- DReady  in  1  stream ready. A transfer occurs when DValid=1 and DReady=1.

## Operation
- Reset values: Busy=0, Done=0, RClk_En=0, RA=0, DValid=0, DOut=0. The FIFO is empty, all counters are 0, and the FSM is in IDLE.
- The FSM has three states:
  - IDLE: Start=1 with Len>0 moves to READ; it latches the address and sets the issue counter and the deliver counter to Len. Start=1 with Len=0 moves to DONE.
  - READ: reads are issued. When the last word has been transferred on the stream, the FSM moves to DONE.
  - DONE: Done=1 for exactly one cycle, then the FSM returns to IDLE.
- Credit rule:
  - A read is issued (RClk_En=1) only when the issue counter is nonzero and (reads in flight + FIFO occupancy) < FIFO_DEPTH.
  - The in-flight count covers the last RD_LATENCY issued reads.
  - Because of this rule, the FIFO never overflows and RD is never dropped.
- Data capture: RD is written into the FIFO exactly RD_LATENCY cycles after the corresponding RClk_En=1. This is tracked with a RD_LATENCY-deep valid shift register.
- Address: RA increments by one after each issued read and wraps from 511 to 0. Len=512 therefore reads the whole RAM starting at StartAddr.
- The deliver counter decrements on each stream transfer. Busy remains high until the deliver counter reaches 0.
- The stream holds its data: DOut and DValid stay stable while DValid=1 and DReady=0.
- Start while Busy=1 is dropped, with no side effect.
- Asserting Rst mid-burst immediately returns all outputs to their reset values and discards the contents of the FIFO. The RAM state is unaffected.

## Timing
- Start accepted at edge 0. The FSM is in READ from edge 0, and RClk_En=1 with RA=StartAddr during cycle 1.
- With RD_LATENCY=1: RD is captured at edge 2, and DValid=1 in cycle 3 when the FIFO output is registered. First-word latency is therefore 3 clocks after Start.
- With DReady held at 1, throughput is 1 word per clock sustained, with no bubbles once the pipeline is primed. This requires FIFO_DEPTH >= RD_LATENCY+2.
- Done is high in the cycle after the final transfer. Busy falls in the same cycle that Done rises.
- A new Start is accepted in the cycle after Done. There are no back-to-back bursts without a gap.
- With Len=0: Done=1 in cycle 1, and RClk_En never rises.

## Structure
- Package ram_rd_pkg contains:
  - the FSM enum (IDLE, READ, DONE);
  - the defaults for ADDR_W and DATA_W;
  - the constant MAX_LEN = 512.
- One sub-module, ram_rd_fifo: a synchronous FIFO with a show-ahead registered output. Its ports are wr_en, wr_data, rd_en, rd_data, empty and count. Its reset is the same asynchronous, active-high Rst.
- The top level holds the FSM, the address, issue and deliver counters, the latency shift register and the credit logic.

## Test plan
- Basic burst: preload RAM[i]=i; StartAddr=10, Len=4, DReady=1. Required: DOut sequence 10,11,12,13; first DValid in cycle 3; one Done pulse; exactly 4 RClk_En pulses.
- Wrap: StartAddr=510, Len=4. Required: RA sequence 510,511,0,1, and the data matches.
- Backpressure: Len=16 with DReady toggling randomly, plus a 20-cycle stall in the middle. Required: every word appears in order, with no loss and no duplication; FIFO occupancy is never above FIFO_DEPTH; DOut stays stable while stalled.
- Edge lengths: Len=0 gives Done in cycle 1 and no reads. Len=600 is clamped, giving exactly 512 words. A Start pulsed while Busy is ignored.
- Registered RAM: RD_LATENCY=2, Len=8, DReady=1. Required: the correct order and 1 word per clock after priming.
- Reset mid-burst: assert Rst after 5 of 16 words. Required: outputs return to reset values immediately. A following burst with Len=3 from address 0 returns RAM[0..2] cleanly.

Source files
------------

// File: rtl/ram_rd_pkg.sv
// Shared types and constants for the 512x16 block-RAM burst reader.
package ram_rd_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;
    localparam int MAX_LEN    = 512;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DONE
    } rd_state_t;

endpackage

// File: rtl/ram_rd_fifo.sv
// Synchronous FIFO with a show-ahead registered output; a write into an empty
// FIFO lands directly in the output register so it is visible one clock later.
module ram_rd_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  mem_cnt;
    logic              out_valid, out_free, mem_rd, mem_wr, bypass;

    assign out_free = !out_valid || rd_en;
    assign mem_rd   = out_free && (mem_cnt != '0);
    assign bypass   = out_free && (mem_cnt == '0) && wr_en;
    assign mem_wr   = wr_en && !bypass;
    assign empty    = !out_valid;
    // Occupancy includes the word parked in the output register.
    assign count    = mem_cnt + CNT_W'(out_valid);

    // NOTE: storage array has no reset; pointers and count define which entries are live.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
            rd_data   <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (mem_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            mem_cnt <= mem_cnt + CNT_W'(mem_wr) - CNT_W'(mem_rd);

            if (mem_rd) begin
                rd_data   <= mem[rd_ptr];
                out_valid <= 1'b1;
            end else if (bypass) begin
                rd_data   <= wr_data;
                out_valid <= 1'b1;
            end else if (rd_en) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ram512x16_burst_reader.sv
// Burst read master: issues credit-limited RAM reads, absorbs the fixed read
// latency and streams the words out in order on a valid/ready interface.
module ram512x16_burst_reader
    import ram_rd_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [ADDR_W:0]   Len,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] RA,
    output logic              RClk_En,
    input  logic [DATA_W-1:0] RD,
    output logic [DATA_W-1:0] DOut,
    output logic              DValid,
    input  logic              DReady
);

    localparam int                 LEN_W   = ADDR_W + 1;
    localparam int                 CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W-1:0]   LEN_CAP = LEN_W'(MAX_LEN);

    rd_state_t             state, state_nxt;
    logic [LEN_W-1:0]      issue_cnt, deliver_cnt, len_clamped;
    logic [RD_LATENCY-1:0] vld_sr;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty, start_ok, xfer, credit_ok;
    int                    in_flight;

    assign len_clamped = (Len > LEN_CAP) ? LEN_CAP : Len;
    assign start_ok    = (state == IDLE) && Start;
    assign xfer        = DValid && DReady;
    assign DValid      = !fifo_empty;
    assign Busy        = (state == READ);
    assign Done        = (state == DONE);

    always_comb begin
        in_flight = 0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight += int'(vld_sr[i]);
        end
    end

    // A slot is reserved in the FIFO for every read still travelling through the RAM.
    assign credit_ok = (in_flight + int'(fifo_count)) < FIFO_DEPTH;
    assign RClk_En   = Busy && (issue_cnt != '0) && credit_ok;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every path assigns state_nxt via the default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt = (len_clamped != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (xfer && (deliver_cnt == LEN_W'(1))) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            RA          <= '0;
            issue_cnt   <= '0;
            deliver_cnt <= '0;
            vld_sr      <= '0;
        end else begin
            vld_sr[0] <= RClk_En;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end

            if (start_ok) begin
                RA          <= StartAddr;
                issue_cnt   <= len_clamped;
                deliver_cnt <= len_clamped;
            end else begin
                if (RClk_En) begin
                    RA        <= RA + 1'b1;
                    issue_cnt <= issue_cnt - 1'b1;
                end
                if (xfer) begin
                    deliver_cnt <= deliver_cnt - 1'b1;
                end
            end
        end
    end

    ram_rd_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (Clk),
        .rst     (Rst),
        .wr_en   (vld_sr[RD_LATENCY-1]),
        .wr_data (RD),
        .rd_en   (xfer),
        .rd_data (DOut),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

endmodule
